cmplx_operand_sequencer: RTL and testbench
==========================================

# cmplx_operand_sequencer

Front-end controller for the complex multiplier top level. It conditions the raw handshake switch with a synchroniser, debouncer and edge detector. On successive handshake releases it captures four switch words (re_a, im_a, re_q, im_q) and issues a one-cycle start to the multiplier core. It then sequences the product onto the LEDs: real part first, imaginary part while handshake is held.

## Interface

Parameters:
- WORD_W, 16, operand/result width; must equal the `WORD_SIZE` width
- DEBOUNCE_CYCLES, 500000, cycles the synchronised switch must hold a new level before it is accepted (10 ms at 50 MHz); benches override to 4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- handshake_sw  in  1  raw handshake switch, asynchronous
- data_sw  in  WORD_W  raw data switches, asynchronous, quasi-static
- start  out  1  one-cycle pulse: operands valid
- re_a, im_a, re_q, im_q  out  WORD_W each  captured operands, two's complement
- res_valid  in  1  one-cycle pulse from multiplier: re_res/im_res valid
- re_res, im_res  in  WORD_W each  product
- led  out  WORD_W  displayed result
- stage  out  3  current FSM state encoding, for HEX display

## Operation

- handshake_sw and data_sw pass through 2-flop synchronisers.
- Debounce applies to handshake only:
  - The counter clears whenever the synchronised value equals the debounced level.
  - Otherwise the counter increments.
  - At count DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
- Edge detector produces registered press (0→1) and release (1→0) pulses from the debounced level.
- FSM states and encodings:
  - LOAD_RE_A=0, LOAD_IM_A=1, LOAD_RE_Q=2, LOAD_IM_Q=3, WAIT_RES=4, SHOW_RE=5, SHOW_IM=6.
- FSM transitions:
  - In each LOAD_x state, a release latches the synchronised data_sw into operand x and advances the state.
  - Release in LOAD_IM_Q also pulses start for one cycle and enters WAIT_RES.
  - WAIT_RES: res_valid latches re_res/im_res into result registers, then goes to SHOW_RE. Press/release events are ignored.
  - SHOW_RE: press → SHOW_IM.
  - SHOW_IM: release → LOAD_RE_A.
- led output by state:
  - 0 in LOAD_* and WAIT_RES.
  - Latched re result in SHOW_RE.
  - Latched im result in SHOW_IM.
- Operand registers hold from start until the next capture into that register. The multiplier may sample them any time before res_valid.
- Events that do not match the current state (e.g. press in LOAD_*) are ignored.

## Timing

- Reset values: all operands 0, results 0, led 0, start 0, stage 0 (LOAD_RE_A), debounced level 0, counter 0.
- Latency from a stable raw transition to the edge pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Operand is written and state advances on the clock edge after the release pulse.
- start is asserted in the first cycle of WAIT_RES, exactly one cycle wide.
- res_valid arriving outside WAIT_RES is ignored.
- res_valid in the same cycle as start is legal and accepted.
- Glitches shorter than DEBOUNCE_CYCLES produce no edge.
- Reset has priority over all events and is asynchronous mid-operation. It returns to LOAD_RE_A, discarding partial operands and any pending result.
- Data value captured = synchronised data_sw in the release-pulse cycle. Changes while the switch is held are therefore tracked.

## Structure

- Package cmplx_pkg: state_t enum (explicit 3-bit encodings above) and WORD_W localparam (shared with the multiplier).
- Sub-module switch_debouncer (parameter DEBOUNCE_CYCLES): synchroniser, debounce counter, press/release pulses.
- Top of block: debouncer instance, data synchroniser, FSM, operand and result registers, led mux.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- Reset asserted mid-LOAD_RE_Q → stage=0, operands=0, led=0 within the same cycle; no start pulse.
- Load 3, 4, 5, 6 → start pulses once with re_a=3, im_a=4, re_q=5, im_q=6. Model returns re=16'hFFF7 (−9), im=16'h0026 (38):
  - led=16'hFFF7 in SHOW_RE.
  - press → led=16'h0026.
  - release → stage=0, led=0.
- handshake_sw glitch high for 2 cycles in LOAD_RE_A → no capture, stage stays 0.
- Press and release during WAIT_RES before res_valid → ignored. A later res_valid → SHOW_RE with correct result.
- data_sw=16'h1234 at press, changed to 16'hABCD before release → re_a=16'hABCD.
- Reset during SHOW_IM → led=0, stage=0. The next four loads operate normally.

Source files
------------

// File: rtl/cmplx_pkg.sv
// Shared types and widths for the complex multiplier front end.
// State encodings are fixed because they drive the HEX stage display.
package cmplx_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        LOAD_RE_A = 3'd0,
        LOAD_IM_A = 3'd1,
        LOAD_RE_Q = 3'd2,
        LOAD_IM_Q = 3'd3,
        WAIT_RES  = 3'd4,
        SHOW_RE   = 3'd5,
        SHOW_IM   = 3'd6
    } state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Purpose: synchronise a raw switch, debounce it, emit press/release pulses.
// Latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles from stable raw edge to pulse.
// Backpressure: none; pulses are one cycle wide and must be consumed or lost.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             level_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Any return to the accepted level restarts the hold window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_q2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_prev    <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level_prev    <= level;
            press         <= level & ~level_prev;
            release_pulse <= ~level & level_prev;
        end
    end

endmodule

// File: rtl/cmplx_operand_sequencer.sv
// Purpose: capture four operands on handshake releases, start the multiplier, show the result.
// Latency: operand written one cycle after the release pulse; start in the first WAIT_RES cycle.
// Backpressure: none; events not matching the current state are dropped.
module cmplx_operand_sequencer #(
    parameter int WORD_W          = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              handshake_sw,
    input  logic [WORD_W-1:0] data_sw,
    output logic              start,
    output logic [WORD_W-1:0] re_a,
    output logic [WORD_W-1:0] im_a,
    output logic [WORD_W-1:0] re_q,
    output logic [WORD_W-1:0] im_q,
    input  logic              res_valid,
    input  logic [WORD_W-1:0] re_res,
    input  logic [WORD_W-1:0] im_res,
    output logic [WORD_W-1:0] led,
    output logic [2:0]        stage
);

    import cmplx_pkg::*;

    state_t            state;
    logic              hs_level;
    logic              hs_press;
    logic              hs_release;
    logic [WORD_W-1:0] data_q1;
    logic [WORD_W-1:0] data_q2;
    logic [WORD_W-1:0] re_r;
    logic [WORD_W-1:0] im_r;

    switch_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_hs_debounce (
        .clk           (clk),
        .reset         (reset),
        .sw_raw        (handshake_sw),
        .level         (hs_level),
        .press         (hs_press),
        .release_pulse (hs_release)
    );

    // Data switches are quasi-static, so a plain per-bit synchroniser is enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q1 <= '0;
            data_q2 <= '0;
        end else begin
            data_q1 <= data_sw;
            data_q2 <= data_q1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_RE_A;
            start <= 1'b0;
            re_a  <= '0;
            im_a  <= '0;
            re_q  <= '0;
            im_q  <= '0;
            re_r  <= '0;
            im_r  <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                LOAD_RE_A: if (hs_release) begin
                    re_a  <= data_q2;
                    state <= LOAD_IM_A;
                end
                LOAD_IM_A: if (hs_release) begin
                    im_a  <= data_q2;
                    state <= LOAD_RE_Q;
                end
                LOAD_RE_Q: if (hs_release) begin
                    re_q  <= data_q2;
                    state <= LOAD_IM_Q;
                end
                LOAD_IM_Q: if (hs_release) begin
                    im_q  <= data_q2;
                    start <= 1'b1;
                    state <= WAIT_RES;
                end
                WAIT_RES: if (res_valid) begin
                    re_r  <= re_res;
                    im_r  <= im_res;
                    state <= SHOW_RE;
                end
                SHOW_RE: if (hs_press) begin
                    state <= SHOW_IM;
                end
                SHOW_IM: if (hs_release) begin
                    state <= LOAD_RE_A;
                end
                default: state <= LOAD_RE_A;
            endcase
        end
    end

    always_comb begin
        led = '0;
        case (state)
            SHOW_RE: led = re_r;
            SHOW_IM: led = im_r;
            default: led = '0;
        endcase
    end

    assign stage = state;

    // Debounced level itself is only observed through its edge pulses.
    logic unused_level;
    assign unused_level = hs_level;

endmodule

// File: tb/tb_cmplx_operand_sequencer.sv
// Directed bench for cmplx_operand_sequencer with a four-cycle debounce window.
module tb_cmplx_operand_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         handshake_sw;
    logic [W-1:0] data_sw;
    logic         start;
    logic [W-1:0] re_a, im_a, re_q, im_q;
    logic         res_valid;
    logic [W-1:0] re_res, im_res;
    logic [W-1:0] led;
    logic [2:0]   stage;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    cmplx_operand_sequencer #(
        .WORD_W          (W),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .handshake_sw (handshake_sw),
        .data_sw      (data_sw),
        .start        (start),
        .re_a         (re_a),
        .im_a         (im_a),
        .re_q         (re_q),
        .im_q         (im_q),
        .res_valid    (res_valid),
        .re_res       (re_res),
        .im_res       (im_res),
        .led          (led),
        .stage        (stage)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start) start_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold the switch high then low, long enough for each edge to be accepted.
    task automatic load_word(input logic [W-1:0] v);
        data_sw = v;
        handshake_sw = 1'b1;
        tick(10);
        handshake_sw = 1'b0;
        tick(10);
    endtask

    task automatic pulse_result(input logic [W-1:0] r, input logic [W-1:0] i);
        re_res = r;
        im_res = i;
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        tick(1);
    endtask

    function automatic logic [W-1:0] cre(input logic signed [W-1:0] ar, ai, qr, qi);
        return W'(ar * qr - ai * qi);
    endfunction

    function automatic logic [W-1:0] cim(input logic signed [W-1:0] ar, ai, qr, qi);
        return W'(ar * qi + ai * qr);
    endfunction

    initial begin : stim
        int sc;
        bit seen;
        reset = 1'b1;
        handshake_sw = 1'b0;
        data_sw = '0;
        res_valid = 1'b0;
        re_res = '0;
        im_res = '0;
        tick(3);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_re_a", 32'(re_a), 32'd0);
        reset = 1'b0;
        tick(2);

        // Partial load, then reset in LOAD_RE_Q.
        load_word(16'd1);
        load_word(16'd2);
        check("partial_stage", 32'(stage), 32'd2);
        check("partial_re_a", 32'(re_a), 32'd1);
        check("partial_im_a", 32'(im_a), 32'd2);
        reset = 1'b1;
        #1;
        check("midrst_stage", 32'(stage), 32'd0);
        check("midrst_re_a", 32'(re_a), 32'd0);
        check("midrst_im_a", 32'(im_a), 32'd0);
        check("midrst_led", 32'(led), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("midrst_no_start", 32'(start_cnt), 32'd0);

        // Two-cycle glitch must not be accepted.
        data_sw = 16'h00EE;
        handshake_sw = 1'b1;
        tick(2);
        handshake_sw = 1'b0;
        tick(15);
        check("glitch_stage", 32'(stage), 32'd0);
        check("glitch_re_a", 32'(re_a), 32'd0);

        // Full transaction 3,4,5,6.
        load_word(16'd3);
        load_word(16'd4);
        load_word(16'd5);
        load_word(16'd6);
        check("full_stage", 32'(stage), 32'd4);
        check("full_start_once", 32'(start_cnt), 32'd1);
        check("full_re_a", 32'(re_a), 32'd3);
        check("full_im_a", 32'(im_a), 32'd4);
        check("full_re_q", 32'(re_q), 32'd5);
        check("full_im_q", 32'(im_q), 32'd6);
        check("full_wait_led", 32'(led), 32'd0);
        pulse_result(cre(3, 4, 5, 6), cim(3, 4, 5, 6));
        check("full_show_re_stage", 32'(stage), 32'd5);
        check("full_show_re_led", 32'(led), 32'h0000FFF7);
        handshake_sw = 1'b1;
        tick(10);
        check("full_show_im_stage", 32'(stage), 32'd6);
        check("full_show_im_led", 32'(led), 32'h00000026);
        handshake_sw = 1'b0;
        tick(10);
        check("full_back_stage", 32'(stage), 32'd0);
        check("full_back_led", 32'(led), 32'd0);

        // res_valid outside WAIT_RES is dropped.
        pulse_result(16'h5555, 16'h6666);
        check("stray_res_stage", 32'(stage), 32'd0);
        check("stray_res_led", 32'(led), 32'd0);

        // Press/release in WAIT_RES is ignored.
        load_word(16'd1);
        load_word(16'd2);
        load_word(16'd3);
        load_word(16'd4);
        check("wait_stage", 32'(stage), 32'd4);
        load_word(16'd9);
        check("wait_ignore_stage", 32'(stage), 32'd4);
        check("wait_ignore_im_q", 32'(im_q), 32'd4);
        check("wait_start_count", 32'(start_cnt), 32'd2);
        pulse_result(cre(1, 2, 3, 4), cim(1, 2, 3, 4));
        check("wait_show_re_stage", 32'(stage), 32'd5);
        check("wait_show_re_led", 32'(led), 32'h0000FFFB);

        // Reset during SHOW_IM.
        handshake_sw = 1'b1;
        tick(10);
        check("showim_stage", 32'(stage), 32'd6);
        check("showim_led", 32'(led), 32'h0000000A);
        reset = 1'b1;
        #1;
        check("showim_rst_stage", 32'(stage), 32'd0);
        check("showim_rst_led", 32'(led), 32'd0);
        handshake_sw = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(4);

        // Data tracked while held; last load answered in the start cycle.
        data_sw = 16'h1234;
        handshake_sw = 1'b1;
        tick(10);
        data_sw = 16'hABCD;
        tick(10);
        handshake_sw = 1'b0;
        tick(10);
        check("track_re_a", 32'(re_a), 32'h0000ABCD);
        check("track_stage", 32'(stage), 32'd1);
        load_word(16'hFFFF);
        load_word(16'd2);
        data_sw = 16'd7;
        handshake_sw = 1'b1;
        tick(10);
        handshake_sw = 1'b0;
        seen = 1'b0;
        for (sc = 0; sc < 20 && !seen; sc++) begin
            tick(1);
            if (start === 1'b1) seen = 1'b1;
        end
        check("same_cycle_start_seen", 32'(seen), 32'd1);
        re_res = cre(16'shABCD, -16'sd1, 16'sd2, 16'sd7);
        im_res = cim(16'shABCD, -16'sd1, 16'sd2, 16'sd7);
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        tick(1);
        check("same_cycle_stage", 32'(stage), 32'd5);
        check("same_cycle_led", 32'(led), 32'(cre(16'shABCD, -16'sd1, 16'sd2, 16'sd7)));
        check("same_cycle_im_a", 32'(im_a), 32'h0000FFFF);
        check("same_cycle_start_total", 32'(start_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
